// File: rtl/teclado_varredura.sv
// Keypad matrix scanner: drives columns one at a time (active-low), samples the
// synchronized rows at the end of each column slot and debounces whole scan frames.
// A debounced press yields a key code plus a one-cycle key_valid pulse.
module teclado_varredura #(
  parameter int unsigned ROWS     = 4,
  parameter int unsigned COLS     = 4,
  parameter int unsigned SCAN_DIV = 16,
  parameter int unsigned DEBOUNCE = 3
) (
  input  logic            clock_i,
  input  logic            reset_i,
  input  logic            enable_i,
  input  logic [ROWS-1:0] row_n_i,
  output logic [COLS-1:0] col_n_o,
  output logic [3:0]      key_code_o,
  output logic            key_valid_o,
  output logic            key_held_o,
  output logic            multi_err_o
);

  localparam int unsigned Keys  = ROWS * COLS;
  localparam int unsigned SlotW = $clog2(SCAN_DIV);
  localparam int unsigned ColW  = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int unsigned CntW  = $clog2(DEBOUNCE + 1);

  typedef enum logic [1:0] {StIdle, StDbPress, StPressed, StDbRel} state_e;

  logic [ROWS-1:0]  row_meta_q, row_sync_q;
  logic             active_q, active_d;
  logic [SlotW-1:0] slot_q, slot_d;
  logic [ColW-1:0]  col_q, col_d;
  logic [Keys-1:0]  acc_q, acc_d;
  logic [COLS-1:0]  col_n_q, col_n_d;

  logic             slot_last, col_last, scan_run, frame_end;
  logic [Keys-1:0]  pressed_now, acc_next;
  logic [4:0]       nkeys;
  logic [3:0]       key_idx;
  logic             is_one, is_none, is_multi;

  state_e           state_q;
  logic [3:0]       cand_q, key_code_q;
  logic [CntW-1:0]  cnt_q;
  logic             key_valid_q, key_held_q, multi_err_q;

  // Two-flop synchronizer for the asynchronous row lines (idle level is high).
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      row_meta_q <= '1;
      row_sync_q <= '1;
    end else begin
      row_meta_q <= row_n_i;
      row_sync_q <= row_meta_q;
    end
  end

  assign slot_last = (slot_q == SlotW'(SCAN_DIV - 1));
  assign col_last  = (col_q == ColW'(COLS - 1));
  // active_q delays the first slot by one cycle so column 0 gets a full slot after enable rises.
  assign scan_run  = enable_i && active_q;
  assign frame_end = scan_run && slot_last && col_last;

  // Decode the current column's row sample and classify the frame including it.
  always_comb begin
    pressed_now = '0;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        pressed_now[r*COLS+c] = (col_q == ColW'(c)) && !row_sync_q[r];
      end
    end
    acc_next = acc_q | (slot_last ? pressed_now : '0);
    nkeys    = '0;
    key_idx  = '0;
    for (int i = 0; i < Keys; i++) begin
      nkeys = nkeys + {4'b0, acc_next[i]};
      if (acc_next[i]) key_idx = 4'(i);
    end
    is_none  = (nkeys == 5'd0);
    is_one   = (nkeys == 5'd1);
    is_multi = (nkeys > 5'd1);
  end

  // Next state of the slot counter, column pointer, accumulator and column drive.
  always_comb begin
    active_d = enable_i;
    slot_d   = slot_q;
    col_d    = col_q;
    acc_d    = acc_q;
    if (!enable_i) begin
      slot_d = '0;
      col_d  = '0;
      acc_d  = '0;
    end else if (active_q) begin
      if (slot_last) begin
        slot_d = '0;
        col_d  = col_last ? '0 : col_q + ColW'(1);
        acc_d  = frame_end ? '0 : acc_next;
      end else begin
        slot_d = slot_q + SlotW'(1);
      end
    end
    col_n_d = '1;
    if (enable_i) col_n_d[col_d] = 1'b0;
  end

  // Scan state registers; col_n is registered so the pins never glitch.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      active_q <= 1'b0;
      slot_q   <= '0;
      col_q    <= '0;
      acc_q    <= '0;
      col_n_q  <= '1;
    end else begin
      active_q <= active_d;
      slot_q   <= slot_d;
      col_q    <= col_d;
      acc_q    <= acc_d;
      col_n_q  <= col_n_d;
    end
  end

  // Debounce FSM, stepped once per completed frame, with registered outputs.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= StIdle;
      cand_q      <= '0;
      cnt_q       <= '0;
      key_code_q  <= '0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
      multi_err_q <= 1'b0;
    end else begin
      key_valid_q <= 1'b0;
      if (!enable_i) begin
        state_q     <= StIdle;
        cand_q      <= '0;
        cnt_q       <= '0;
        key_held_q  <= 1'b0;
        multi_err_q <= 1'b0;
      end else if (frame_end) begin
        multi_err_q <= is_multi;
        unique case (state_q)
          StIdle: begin
            if (is_one) begin
              cand_q <= key_idx;
              if (DEBOUNCE <= 1) begin
                state_q     <= StPressed;
                key_code_q  <= key_idx;
                key_valid_q <= 1'b1;
                key_held_q  <= 1'b1;
                cnt_q       <= '0;
              end else begin
                state_q <= StDbPress;
                cnt_q   <= CntW'(1);
              end
            end
          end
          StDbPress: begin
            if (is_one && key_idx == cand_q) begin
              if (32'(cnt_q) + 32'd1 >= DEBOUNCE) begin
                state_q     <= StPressed;
                key_code_q  <= cand_q;
                key_valid_q <= 1'b1;
                key_held_q  <= 1'b1;
                cnt_q       <= '0;
              end else begin
                cnt_q <= cnt_q + CntW'(1);
              end
            end else if (is_one) begin
              cand_q <= key_idx;
              cnt_q  <= CntW'(1);
            end else begin
              state_q <= StIdle;
              cnt_q   <= '0;
            end
          end
          StPressed: begin
            if (is_none) begin
              if (DEBOUNCE <= 1) begin
                state_q    <= StIdle;
                key_held_q <= 1'b0;
                cnt_q      <= '0;
              end else begin
                state_q <= StDbRel;
                cnt_q   <= CntW'(1);
              end
            end
          end
          StDbRel: begin
            if (is_none) begin
              if (32'(cnt_q) + 32'd1 >= DEBOUNCE) begin
                state_q    <= StIdle;
                key_held_q <= 1'b0;
                cnt_q      <= '0;
              end else begin
                cnt_q <= cnt_q + CntW'(1);
              end
            end else begin
              // Bounce during release: back to held, no new pulse.
              state_q <= StPressed;
              cnt_q   <= '0;
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign col_n_o     = col_n_q;
  assign key_code_o  = key_code_q;
  assign key_valid_o = key_valid_q;
  assign key_held_o  = key_held_q;
  assign multi_err_o = multi_err_q;

endmodule

// File: tb/tb_teclado_varredura.sv
// Directed bench for teclado_varredura with a behavioural keypad matrix model.
module tb_teclado_varredura;

  logic        clock_i = 1'b0;
  logic        reset_i;
  logic        enable_i;
  logic [3:0]  row_n;
  logic [3:0]  col_n;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_held;
  logic        multi_err;
  logic [15:0] keys;

  int checks   = 0;
  int failures = 0;
  int pulses   = 0;
  int p0;

  teclado_varredura #(
    .ROWS    (4),
    .COLS    (4),
    .SCAN_DIV(16),
    .DEBOUNCE(3)
  ) dut (
    .clock_i    (clock_i),
    .reset_i    (reset_i),
    .enable_i   (enable_i),
    .row_n_i    (row_n),
    .col_n_o    (col_n),
    .key_code_o (key_code),
    .key_valid_o(key_valid),
    .key_held_o (key_held),
    .multi_err_o(multi_err)
  );

  always #5 clock_i = ~clock_i;

  // Keypad: a closed switch pulls its row low while its column is driven low.
  always_comb begin
    row_n = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (keys[r*4+c] && !col_n[c]) row_n[r] = 1'b0;
      end
    end
  end

  always @(posedge clock_i) begin
    if (key_valid) pulses <= pulses + 1;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clock_i);
    #1;
  endtask

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  initial begin
    reset_i  = 1'b1;
    enable_i = 1'b0;
    keys     = 16'h0;
    #2;
    check_eq("rst_col_n", 32'(col_n), 32'hF);
    check_eq("rst_code", 32'(key_code), 32'h0);
    check_eq("rst_valid", 32'(key_valid), 32'h0);
    check_eq("rst_held", 32'(key_held), 32'h0);
    check_eq("rst_multi", 32'(multi_err), 32'h0);
    tick(2);
    reset_i = 1'b0;
    tick(1);

    // Column walk: 16 cycles per column, starting at column 0.
    enable_i = 1'b1;
    tick(1);
    check_eq("scan_c0_first", 32'(col_n), 32'hE);
    tick(15);
    check_eq("scan_c0_last", 32'(col_n), 32'hE);
    tick(1);
    check_eq("scan_c1", 32'(col_n), 32'hD);
    tick(16);
    check_eq("scan_c2", 32'(col_n), 32'hB);
    tick(16);
    check_eq("scan_c3", 32'(col_n), 32'h7);
    tick(16);
    check_eq("scan_wrap", 32'(col_n), 32'hE);
    enable_i = 1'b0;
    tick(1);
    check_eq("disable_col_n", 32'(col_n), 32'hF);

    // Key 9 (row 2, col 1) held 5 frames: accepted after the 3rd frame end.
    keys     = 16'h0200;
    enable_i = 1'b1;
    p0       = pulses;
    tick(192);
    check_eq("press_early_valid", 32'(key_valid), 32'h0);
    check_eq("press_early_held", 32'(key_held), 32'h0);
    tick(1);
    check_eq("press_valid", 32'(key_valid), 32'h1);
    check_eq("press_code", 32'(key_code), 32'h9);
    check_eq("press_held", 32'(key_held), 32'h1);
    tick(1);
    check_eq("press_pulse_1cyc", 32'(key_valid), 32'h0);
    tick(127);
    check_eq("press_one_pulse", 32'(pulses - p0), 32'h1);
    check_eq("press_no_multi", 32'(multi_err), 32'h0);

    // Release: key_held falls at the end of the 3rd empty frame, code kept.
    keys = 16'h0;
    tick(191);
    check_eq("rel_held_still", 32'(key_held), 32'h1);
    tick(1);
    check_eq("rel_held_low", 32'(key_held), 32'h0);
    check_eq("rel_code_kept", 32'(key_code), 32'h9);
    keys = 16'h0200;
    p0   = pulses;
    tick(192);
    check_eq("repress_valid", 32'(key_valid), 32'h1);
    check_eq("repress_code", 32'(key_code), 32'h9);
    tick(1);
    check_eq("repress_one_pulse", 32'(pulses - p0), 32'h1);

    // Bounce: 2 frames on, 1 off, 3 on -> one pulse after the last of the 3.
    enable_i = 1'b0;
    tick(1);
    check_eq("dis_held", 32'(key_held), 32'h0);
    check_eq("dis_code_kept", 32'(key_code), 32'h9);
    keys     = 16'h0200;
    enable_i = 1'b1;
    p0       = pulses;
    tick(129);
    keys = 16'h0;
    tick(64);
    keys = 16'h0200;
    tick(191);
    check_eq("bounce_no_early", 32'(pulses - p0), 32'h0);
    tick(1);
    check_eq("bounce_valid", 32'(key_valid), 32'h1);
    tick(1);

    // Keys 0 and 5 together -> multi_err, then key 0 alone is accepted.
    enable_i = 1'b0;
    tick(1);
    keys     = 16'h0021;
    enable_i = 1'b1;
    p0       = pulses;
    tick(65);
    check_eq("multi_set", 32'(multi_err), 32'h1);
    check_eq("multi_no_valid", 32'(key_valid), 32'h0);
    keys = 16'h0001;
    tick(64);
    check_eq("multi_clear", 32'(multi_err), 32'h0);
    tick(127);
    check_eq("multi_no_pulse", 32'(pulses - p0), 32'h0);
    tick(1);
    check_eq("key0_valid", 32'(key_valid), 32'h1);
    check_eq("key0_code", 32'(key_code), 32'h0);
    tick(1);

    // enable drop mid debounce: progress is lost, scan restarts at column 0.
    enable_i = 1'b0;
    tick(1);
    keys     = 16'h0200;
    enable_i = 1'b1;
    p0       = pulses;
    tick(75);
    enable_i = 1'b0;
    tick(1);
    check_eq("drop_col_n", 32'(col_n), 32'hF);
    check_eq("drop_held", 32'(key_held), 32'h0);
    enable_i = 1'b1;
    tick(1);
    check_eq("restart_col0", 32'(col_n), 32'hE);
    tick(191);
    check_eq("restart_no_early", 32'(pulses - p0), 32'h0);
    tick(1);
    check_eq("restart_valid", 32'(key_valid), 32'h1);

    // Asynchronous reset mid debounce.
    enable_i = 1'b0;
    tick(1);
    enable_i = 1'b1;
    tick(75);
    p0      = pulses;
    reset_i = 1'b1;
    #1;
    check_eq("arst_col_n", 32'(col_n), 32'hF);
    check_eq("arst_code", 32'(key_code), 32'h0);
    check_eq("arst_held", 32'(key_held), 32'h0);
    tick(1);
    reset_i = 1'b0;
    tick(1);
    check_eq("arst_restart_col0", 32'(col_n), 32'hE);
    tick(191);
    check_eq("arst_no_early", 32'(pulses - p0), 32'h0);
    tick(1);
    check_eq("arst_valid", 32'(key_valid), 32'h1);
    check_eq("arst_code9", 32'(key_code), 32'h9);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
